// File: rtl/and_stim_checker.sv
// Stimulus initiator and result checker for a WIDTH-bit 2-input AND unit.
// Drives an exhaustive counting pattern on A/B, keeps the predicted A&B in
// a DUV_LATENCY-deep expected pipeline, compares against Y and reports a
// saturating error count, the first failing vector index and pass/done.
//
// Handshake: there is no valid/ready pair. A run is requested by holding
// start high at a rising edge while the checker is in IDLE or DONE; start
// is ignored while busy. Results are final once done is high and hold
// until the next start.
module and_stim_checker #(
  parameter int WIDTH       = 1,
  parameter int DUV_LATENCY = 1,
  parameter int NUM_VECTORS = 16,
  parameter int ERR_CNT_W   = 8,
  parameter int VEC_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [VEC_W-1:0]     vec_cnt,
  output logic [VEC_W-1:0]     first_err_idx,
  output logic [1:0]           dbg_state
);

  localparam int CW = 2 * WIDTH;
  localparam int PL = (DUV_LATENCY > 0) ? DUV_LATENCY : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [VEC_W-1:0]     LAST_VEC   = VEC_W'(NUM_VECTORS);
  localparam logic [2:0]           DRAIN_LAST = 3'(PL - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, a_d, b_d;
  logic [CW-1:0]        cnt_q, src_cnt;
  logic [VEC_W-1:0]     vec_q, src_idx;
  logic                 cur_vld_q;
  logic [VEC_W-1:0]     cur_idx_q;
  logic [2:0]           drain_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [VEC_W-1:0]     fidx_q, fidx_d;
  logic                 busy_q, done_q, pass_q;
  logic                 launch, restart;
  logic                 cmp_vld, mismatch;
  logic [WIDTH-1:0]     cmp_exp;
  logic [VEC_W-1:0]     cmp_idx;

  assign A             = a_q;
  assign B             = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign vec_cnt       = vec_q;
  assign first_err_idx = fidx_q;
  assign dbg_state     = state_q;

  // Next state and vector launch decision.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    restart = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          launch  = 1'b1;
          restart = 1'b1;
        end
      end
      S_DRIVE: begin
        if (vec_q == LAST_VEC) begin
          state_d = (DUV_LATENCY > 0) ? S_DRAIN : S_DONE;
        end else begin
          launch = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern source: a restart launches vector 0 regardless of old counters.
  always_comb begin
    src_cnt = restart ? '0 : cnt_q;
    src_idx = restart ? '0 : vec_q;
    a_d     = launch ? src_cnt[WIDTH-1:0]  : '0;
    b_d     = launch ? src_cnt[CW-1:WIDTH] : '0;
  end

  // Expected-value alignment: zero latency compares the vector on A/B now.
  if (DUV_LATENCY > 0) begin : g_pipe
    logic             pv_q [PL];
    logic [WIDTH-1:0] pe_q [PL];
    logic [VEC_W-1:0] pi_q [PL];

    // Shift {valid, A&B, index} one stage per clock.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < PL; i++) begin
          pv_q[i] <= 1'b0;
          pe_q[i] <= '0;
          pi_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= cur_vld_q;
        pe_q[0] <= a_q & b_q;
        pi_q[0] <= cur_idx_q;
        for (int i = 1; i < PL; i++) begin
          pv_q[i] <= pv_q[i-1];
          pe_q[i] <= pe_q[i-1];
          pi_q[i] <= pi_q[i-1];
        end
      end
    end

    assign cmp_vld = pv_q[PL-1];
    assign cmp_exp = pe_q[PL-1];
    assign cmp_idx = pi_q[PL-1];
  end else begin : g_nopipe
    assign cmp_vld = cur_vld_q;
    assign cmp_exp = a_q & b_q;
    assign cmp_idx = cur_idx_q;
  end

  // Compare and error bookkeeping; X/Z on Y counts as a mismatch.
  always_comb begin
    mismatch = cmp_vld && (Y !== cmp_exp);
    err_d    = err_q;
    fidx_d   = fidx_q;
    if (restart) begin
      err_d  = '0;
      fidx_d = '1;
    end else if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (err_q == '0)      fidx_d = cmp_idx;
    end
  end

  // State, stimulus, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      vec_q     <= '0;
      cur_vld_q <= 1'b0;
      cur_idx_q <= '0;
      drain_q   <= '0;
      err_q     <= '0;
      fidx_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cur_vld_q <= launch;
      if (launch) begin
        cnt_q     <= src_cnt + 1'b1;
        vec_q     <= src_idx + 1'b1;
        cur_idx_q <= src_idx;
      end
      drain_q   <= (state_q == S_DRAIN) ? drain_q + 3'd1 : 3'd0;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      busy_q    <= (state_d == S_DRIVE) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
      pass_q    <= (state_d == S_DONE) && (err_d == '0);
    end
  end

endmodule

// File: tb/tb_and_stim_checker.sv
// Bench for and_stim_checker: three checker instances with different
// parameter sets, each wired to a bench-side model of the unit under test
// whose behaviour (correct AND, stuck-at, OR, random flips) is selectable.
module tb_and_stim_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int tests = 0;
  int fails = 0;

  // Unit-under-test behaviour per instance: 0 AND, 1 stuck0, 2 stuck1,
  // 3 OR, 4 AND with bit0 flipped for operand pairs marked in bad[].
  int mode [3];
  bit bad  [3][16];

  // u0: WIDTH=1, L=1, N=16, ERR_CNT_W=8
  logic       start0;
  logic [0:0] a0, b0, y0;
  logic       busy0, done0, pass0;
  logic [7:0] err0;
  logic [4:0] vc0, fi0;
  logic [1:0] st0;
  // u1: WIDTH=2, L=3, N=40, ERR_CNT_W=2
  logic       start1;
  logic [1:0] a1, b1, y1, p1a, p1b;
  logic       busy1, done1, pass1;
  logic [1:0] err1;
  logic [5:0] vc1, fi1;
  logic [1:0] st1;
  // u2: WIDTH=1, L=0, N=16, ERR_CNT_W=4
  logic       start2;
  logic [0:0] a2, b2, y2;
  logic       busy2, done2, pass2;
  logic [3:0] err2;
  logic [4:0] vc2, fi2;
  logic [1:0] st2;

  and_stim_checker #(.WIDTH(1), .DUV_LATENCY(1), .NUM_VECTORS(16), .ERR_CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .Y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .vec_cnt(vc0), .first_err_idx(fi0), .dbg_state(st0));
  and_stim_checker #(.WIDTH(2), .DUV_LATENCY(3), .NUM_VECTORS(40), .ERR_CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .vec_cnt(vc1), .first_err_idx(fi1), .dbg_state(st1));
  and_stim_checker #(.WIDTH(1), .DUV_LATENCY(0), .NUM_VECTORS(16), .ERR_CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .vec_cnt(vc2), .first_err_idx(fi2), .dbg_state(st2));

  // Behavioural unit under test: operand pair -> result for given mode.
  function automatic logic [1:0] duv_f(input int inst, input int w,
                                       input logic [1:0] a, input logic [1:0] b);
    logic [3:0] idx;
    logic [1:0] r;
    idx = (w == 1) ? {2'b00, b[0], a[0]} : {b, a};
    case (mode[inst])
      0:       r = a & b;
      1:       r = 2'b00;
      2:       r = (w == 1) ? 2'b01 : 2'b11;
      3:       r = a | b;
      default: r = (a & b) ^ {1'b0, bad[inst][idx]};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : duv0
    logic [1:0] t;
    t = duv_f(0, 1, {1'b0, a0}, {1'b0, b0});
    y0 <= t[0];
  end

  always @(posedge clk) begin
    p1a <= duv_f(1, 2, a1, b1);
    p1b <= p1a;
    y1  <= p1b;
  end

  always_comb begin
    case (mode[2])
      0:       y2 = a2 & b2;
      1:       y2 = 1'b0;
      2:       y2 = 1'b1;
      3:       y2 = a2 | b2;
      default: y2 = (a2 & b2) ^ bad[2][{2'b00, b2, a2}];
    endcase
  end

  // Reference: expected final err_cnt / first_err_idx from the pattern rules.
  task automatic model(input int inst, input int w, input int n, input int ew,
                       output int exp_err, output int exp_fidx);
    int cnt, fidx, c, a, b, want, got, vw;
    logic [1:0] r;
    cnt  = 0;
    fidx = -1;
    for (int j = 0; j < n; j++) begin
      c    = j % (1 << (2 * w));
      a    = c % (1 << w);
      b    = c / (1 << w);
      want = a & b;
      r    = duv_f(inst, w, 2'(a), 2'(b));
      got  = int'(r) % (1 << w);
      if (got != want) begin
        if (cnt == 0) fidx = j;
        cnt++;
      end
    end
    exp_err  = (cnt > (1 << ew) - 1) ? (1 << ew) - 1 : cnt;
    vw       = $clog2(n + 1);
    exp_fidx = (fidx < 0) ? (1 << vw) - 1 : fidx;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic sample(input int inst, output logic [31:0] a, output logic [31:0] b,
                        output logic [31:0] bz, output logic [31:0] dn, output logic [31:0] ps,
                        output logic [31:0] er, output logic [31:0] vc, output logic [31:0] fi);
    case (inst)
      0: begin
        a = 32'(a0); b = 32'(b0); bz = 32'(busy0); dn = 32'(done0); ps = 32'(pass0);
        er = 32'(err0); vc = 32'(vc0); fi = 32'(fi0);
      end
      1: begin
        a = 32'(a1); b = 32'(b1); bz = 32'(busy1); dn = 32'(done1); ps = 32'(pass1);
        er = 32'(err1); vc = 32'(vc1); fi = 32'(fi1);
      end
      default: begin
        a = 32'(a2); b = 32'(b2); bz = 32'(busy2); dn = 32'(done2); ps = 32'(pass2);
        er = 32'(err2); vc = 32'(vc2); fi = 32'(fi2);
      end
    endcase
  endtask

  // One full run with timing, pattern and result checks.
  task automatic run_check(input string nm, input int inst, input int w, input int n,
                           input int l, input int ew, input int m, input bit hold);
    logic [31:0] a, b, bz, dn, ps, er, vc, fi;
    int seq_err, bsy_err, c, exp_err, exp_fi;
    mode[inst] = m;
    for (int i = 0; i < 16; i++) bad[inst][i] = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 4)) @(negedge clk);
    set_start(inst, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(inst, 1'b0);
    seq_err = 0;
    bsy_err = 0;
    for (int cyc = 1; cyc <= n + l; cyc++) begin
      @(negedge clk);
      sample(inst, a, b, bz, dn, ps, er, vc, fi);
      if (cyc <= n) begin
        c = (cyc - 1) % (1 << (2 * w));
        if (a !== 32'(c % (1 << w)) || b !== 32'(c / (1 << w))) seq_err++;
      end else if (a !== 32'd0 || b !== 32'd0) seq_err++;
      if (bz !== 32'd1 || dn !== 32'd0) bsy_err++;
    end
    @(negedge clk);
    sample(inst, a, b, bz, dn, ps, er, vc, fi);
    model(inst, w, n, ew, exp_err, exp_fi);
    tests++;
    if (seq_err !== 0) begin
      fails++; $display("FAIL %s ab_seq: %0d bad cycles, want 0", nm, seq_err);
    end
    tests++;
    if (bsy_err !== 0) begin
      fails++; $display("FAIL %s busy_window: %0d bad cycles, want 0", nm, bsy_err);
    end
    tests++;
    if (dn !== 32'd1 || bz !== 32'd0) begin
      fails++; $display("FAIL %s done_timing: done=%0d busy=%0d at cycle k+%0d, want 1/0", nm, dn, bz, n + l + 1);
    end
    tests++;
    if (er !== 32'(exp_err)) begin
      fails++; $display("FAIL %s err_cnt: got %0d want %0d", nm, er, exp_err);
    end
    tests++;
    if (ps !== 32'(exp_err == 0)) begin
      fails++; $display("FAIL %s pass: got %0d want %0d", nm, ps, exp_err == 0);
    end
    tests++;
    if (vc !== 32'(n)) begin
      fails++; $display("FAIL %s vec_cnt: got %0d want %0d", nm, vc, n);
    end
    tests++;
    if (fi !== 32'(exp_fi)) begin
      fails++; $display("FAIL %s first_err_idx: got %0d want %0d", nm, fi, exp_fi);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] a, b, bz, dn, ps, er, vc, fi;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sample(i, a, b, bz, dn, ps, er, vc, fi);
      tests++;
      if (a !== 0 || b !== 0 || bz !== 0 || dn !== 0 || ps !== 0 || er !== 0 || vc !== 0 ||
          fi !== ((i == 1) ? 32'd63 : 32'd31)) begin
        fails++;
        $display("FAIL reset_u%0d: a=%0d b=%0d busy=%0d done=%0d pass=%0d err=%0d vc=%0d fi=%0d", i, a, b, bz, dn, ps, er, vc, fi);
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_patterns();
    run_check("correct", 0, 1, 16, 1, 8, 0, 1'b0);
    run_check("stuck0", 0, 1, 16, 1, 8, 1, 1'b0);
    run_check("or_duv", 0, 1, 16, 1, 8, 3, 1'b0);
    for (int r = 0; r < 3; r++) run_check("rand_u0", 0, 1, 16, 1, 8, 4, 1'b0);
  endtask

  task automatic test_saturate();
    run_check("sat_stuck1", 1, 2, 40, 3, 2, 2, 1'b0);
  endtask

  task automatic test_latency();
    run_check("lat0_and", 2, 1, 16, 0, 4, 0, 1'b0);
    run_check("lat3_and", 1, 2, 40, 3, 2, 0, 1'b0);
    run_check("lat0_rand", 2, 1, 16, 0, 4, 4, 1'b0);
    run_check("lat3_rand", 1, 2, 40, 3, 2, 4, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [31:0] a, b, bz, dn, ps, er, vc, fi;
    mode[0] = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    sample(0, a, b, bz, dn, ps, er, vc, fi);
    tests++;
    if (vc !== 32'd7 || a !== 32'd0 || b !== 32'd1) begin
      fails++; $display("FAIL midrst_pre: vc=%0d a=%0d b=%0d, want 7/0/1", vc, a, b);
    end
    rst = 1'b0;
    #1;
    sample(0, a, b, bz, dn, ps, er, vc, fi);
    tests++;
    if (a !== 0 || b !== 0 || bz !== 0 || dn !== 0 || ps !== 0 || er !== 0 || vc !== 0 || fi !== 32'd31) begin
      fails++;
      $display("FAIL midrst_outputs: a=%0d b=%0d busy=%0d done=%0d pass=%0d err=%0d vc=%0d fi=%0d", a, b, bz, dn, ps, er, vc, fi);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start_held();
    logic [31:0] a, b, bz, dn, ps, er, vc, fi;
    int guard;
    run_check("held_stuck0", 0, 1, 16, 1, 8, 1, 1'b1);
    @(posedge clk);
    #1;
    mode[0] = 0;
    sample(0, a, b, bz, dn, ps, er, vc, fi);
    tests++;
    if (er !== 0 || bz !== 1 || dn !== 0 || fi !== 32'd31 || vc !== 1) begin
      fails++; $display("FAIL restart_clear: err=%0d busy=%0d done=%0d fi=%0d vc=%0d, want 0/1/0/31/1", er, bz, dn, fi, vc);
    end
    start0 = 1'b0;
    guard = 0;
    while (done0 !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    sample(0, a, b, bz, dn, ps, er, vc, fi);
    tests++;
    if (dn !== 1 || ps !== 1 || er !== 0 || vc !== 16) begin
      fails++; $display("FAIL restart_run: done=%0d pass=%0d err=%0d vc=%0d, want 1/1/0/16", dn, ps, er, vc);
    end
  endtask

  initial begin
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) mode[i] = 0;
    test_reset();
    test_patterns();
    test_saturate();
    test_latency();
    test_mid_reset();
    test_start_held();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
